// File: rtl/sample_rle_encoder.sv
// Run-length encoder for 32-bit playback samples, with an 8-deep (by default) record FIFO.
// Optional dropped-record counter enabled by defining SAMPLE_RLE_STATS_EN.
module sample_rle_encoder #(
  parameter int COUNT_BITS = 16,
  parameter int FIFO_LOG2  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [COUNT_BITS-1:0] out_count,
`ifdef SAMPLE_RLE_STATS_EN
  output logic [15:0]           dropped_count,
`endif
  output logic                  overflow
);

  // state | meaning
  // IDLE  | no run open
  // RUN   | run value and count held, waiting for a mismatch or flush
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [COUNT_BITS-1:0] CNT_ONE  = COUNT_BITS'(1);
  localparam logic [COUNT_BITS-1:0] CNT_MAX  = {COUNT_BITS{1'b1}};
  localparam logic [FIFO_LOG2:0]    OCC_FULL = (FIFO_LOG2+1)'(DEPTH);

  logic [0:0]            state, state_n;
  logic [31:0]           run_value, run_value_n;
  logic [COUNT_BITS-1:0] run_count, run_count_n;
  logic                  flush_pend, flush_pend_n;
  logic                  push;

  logic [31:0]           mem_data  [DEPTH];
  logic [COUNT_BITS-1:0] mem_count [DEPTH];
  logic [FIFO_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0]    occ;
  logic                  full, pop, wr_en, drop;

  always_comb begin
    push         = 1'b0;
    state_n      = state;
    run_value_n  = run_value;
    run_count_n  = run_count;
    flush_pend_n = flush_pend;
    if (in_valid) begin
      // A flush arriving with a sample waits until a sample-free cycle.
      flush_pend_n = flush | flush_pend;
      if (state == IDLE) begin
        state_n     = RUN;
        run_value_n = in_data;
        run_count_n = CNT_ONE;
      end else if (in_data == run_value && run_count != CNT_MAX) begin
        run_count_n = run_count + CNT_ONE;
      end else begin
        push        = 1'b1;
        run_value_n = in_data;
        run_count_n = CNT_ONE;
      end
    end else if (flush | flush_pend) begin
      flush_pend_n = 1'b0;
      if (state == RUN) begin
        push    = 1'b1;
        state_n = IDLE;
      end
    end
  end

  assign out_valid = (occ != '0);
  assign full      = (occ == OCC_FULL);
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      run_value  <= '0;
      run_count  <= '0;
      flush_pend <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      run_value  <= '0;
      run_count  <= '0;
      flush_pend <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      run_value  <= run_value_n;
      run_count  <= run_count_n;
      flush_pend <= flush_pend_n;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      occ <= occ + 1'b1;
      else if (!wr_en && pop) occ <= occ - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem_data[wr_ptr]  <= run_value;
      mem_count[wr_ptr] <= run_count;
    end
  end

  assign out_data  = out_valid ? mem_data[rd_ptr]  : '0;
  assign out_count = out_valid ? mem_count[rd_ptr] : '0;

`ifdef SAMPLE_RLE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        dropped_count <= '0;
    else if (clear)                      dropped_count <= '0;
    else if (drop && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sample_rle_encoder.sv
// Directed bench for sample_rle_encoder: default instance plus a COUNT_BITS=4 instance
// sharing the same stimulus, records captured from each output port into queues.
module tb_sample_rle_encoder;

  logic        clk = 1'b0;
  logic        reset_n, clear, in_valid, flush, out_ready;
  logic [31:0] in_data;

  logic        out_valid, overflow, out_valid4, overflow4;
  logic [31:0] out_data, out_data4;
  logic [15:0] out_count;
  logic [3:0]  out_count4;
`ifdef SAMPLE_RLE_STATS_EN
  logic [15:0] dropped_count, dropped_count4;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [47:0] q16[$];
  logic [47:0] q4[$];

  always #5 clk = ~clk;

  sample_rle_encoder dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count),
`ifdef SAMPLE_RLE_STATS_EN
    .dropped_count(dropped_count),
`endif
    .overflow(overflow)
  );

  sample_rle_encoder #(.COUNT_BITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_count(out_count4),
`ifdef SAMPLE_RLE_STATS_EN
    .dropped_count(dropped_count4),
`endif
    .overflow(overflow4)
  );

  // Inputs change 1 time unit after posedge, so negedge sees what the next edge will pop.
  always @(negedge clk) begin
    if (out_valid && out_ready)  q16.push_back({out_data, out_count});
    if (out_valid4 && out_ready) q4.push_back({out_data4, 12'd0, out_count4});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rec(input logic [31:0] d, input logic [15:0] c);
    return {d, c};
  endfunction

  function automatic logic [47:0] q16_at(input int i);
    return (i < q16.size()) ? q16[i] : 48'hFFFF_FFFF_FFFF;
  endfunction

  function automatic logic [47:0] q4_at(input int i);
    return (i < q4.size()) ? q4[i] : 48'hFFFF_FFFF_FFFF;
  endfunction

  task automatic step(input logic iv, input logic [31:0] d, input logic fl, input logic rdy);
    @(posedge clk); #1;
    in_valid = iv; in_data = d; flush = fl; out_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, rdy);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    q16.delete();
    q4.delete();
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); #1; reset_n = 1'b1;

    // 5,5,5,9 then flush
    do_clear();
    step(1, 5, 0, 1); step(1, 5, 0, 1); step(1, 5, 0, 1); step(1, 9, 0, 1);
    chk("basic_nohead_yet", out_valid, 0);
    step(0, 0, 1, 1);
    chk("basic_head_valid", out_valid, 1);
    chk("basic_head_rec", {out_data, out_count}, rec(5, 3));
    idle(4, 1);
    chk("basic_nrec", q16.size(), 2);
    chk("basic_rec0", q16_at(0), rec(5, 3));
    chk("basic_rec1", q16_at(1), rec(9, 1));
    chk("basic_drained", out_valid, 0);
    chk("basic_data_zero", out_data, 0);
    step(0, 0, 1, 1);
    idle(3, 1);
    chk("idle_flush_norec", q16.size(), 2);

    // 17 x 0xA: 4-bit counter saturates at 15 and splits the run
    do_clear();
    for (int i = 0; i < 17; i++) step(1, 32'hA, 0, 1);
    step(0, 0, 1, 1);
    idle(4, 1);
    chk("sat4_nrec", q4.size(), 2);
    chk("sat4_rec0", q4_at(0), rec(32'hA, 15));
    chk("sat4_rec1", q4_at(1), rec(32'hA, 2));
    chk("sat16_nrec", q16.size(), 1);
    chk("sat16_rec0", q16_at(0), rec(32'hA, 17));

    // Backpressure: 10 alternating samples + flush -> 10 records, 8 kept, 2 dropped
    do_clear();
    for (int i = 0; i < 10; i++) step(1, (i % 2 == 0) ? 32'd1 : 32'd2, 0, 0);
    step(0, 0, 1, 0);
    idle(2, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_head_rec", {out_data, out_count}, rec(1, 1));
`ifdef SAMPLE_RLE_STATS_EN
    chk("ovf_dropped", dropped_count, 2);
`endif
    idle(3, 0);
    chk("ovf_head_stable", out_data, 1);
    idle(10, 1);
    chk("ovf_nrec", q16.size(), 8);
    for (int i = 0; i < 8; i++) chk("ovf_rec", q16_at(i), rec((i % 2 == 0) ? 32'd1 : 32'd2, 1));
    chk("ovf_sticky", overflow, 1);
    do_clear();
    chk("clear_ovf", overflow, 0);
`ifdef SAMPLE_RLE_STATS_EN
    chk("clear_dropped", dropped_count, 0);
`endif

    // Flush coincident with a new sample after run (3,4)
    do_clear();
    for (int i = 0; i < 4; i++) step(1, 3, 0, 1);
    step(1, 7, 1, 1);
    idle(4, 1);
    chk("coflush_nrec", q16.size(), 2);
    chk("coflush_rec0", q16_at(0), rec(3, 4));
    chk("coflush_rec1", q16_at(1), rec(7, 1));

    // Pending flush survives a following sample
    do_clear();
    step(1, 8, 1, 1); step(1, 8, 0, 1);
    idle(4, 1);
    chk("pend_nrec", q16.size(), 1);
    chk("pend_rec0", q16_at(0), rec(8, 2));

    // Reset mid-run of 6 with a record (4,1) waiting at the head
    do_clear();
    step(1, 4, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 6, 0, 0);
    step(0, 0, 0, 0);
    chk("rstmid_head_pre", {out_data, out_count}, rec(4, 1));
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_data", out_data, 0);
    chk("rstmid_count", out_count, 0);
    @(posedge clk); #1; reset_n = 1'b1;
    q16.delete();
    step(0, 0, 1, 1);
    idle(4, 1);
    chk("rstmid_norec", q16.size(), 0);

    // Full FIFO with simultaneous pop and push
    do_clear();
    for (int i = 1; i <= 9; i++) step(1, i, 0, 0);
    step(1, 10, 0, 1);
    step(0, 0, 0, 0);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_popped", q16.size(), 1);
    chk("fullpp_head", {out_data, out_count}, rec(2, 1));
    step(0, 0, 1, 1);
    idle(12, 1);
    chk("fullpp_nrec", q16.size(), 10);
    for (int i = 0; i < 10; i++) chk("fullpp_rec", q16_at(i), rec(i + 1, 1));
    chk("fullpp_ovf_end", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
